// File: rtl/dnn_host_ctrl_if.sv
// dnn_host_ctrl_if
//   Generic valid/ready stream used on both sides of the DNN host controller.
//   W     : payload width
//   valid : payload valid, driven by the producer
//   ready : consumer can take the payload this cycle
//   data  : payload, transferred when valid & ready
//   master: producer view, slave: consumer view
interface dnn_host_ctrl_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dnn_host_ctrl.sv
// dnn_host_ctrl
//   Host-side driver for the 4-input / 2-output DNN inference core. Input
//   samples arrive one per beat and are staged four at a time; each full
//   vector is launched to the core with a one-cycle in_ready strobe and the
//   result pair is captured a fixed LATENCY cycles later and offered
//   downstream until accepted.
//
//   Parameters
//     I_W      signed sample width (matches the core input width)
//     O_W      signed result width (I_W+13)
//     LATENCY  cycles from the in_ready cycle to the result sample, 2..15
//
//   Ports
//     clk, rst_n            clock, async active-low reset
//     s                     sample stream in  (data = I_W signed sample)
//     m                     result stream out (data = {m_out0, m_out1})
//     x0..x3                registered vector to the core
//     in_ready              registered launch strobe to the core
//     out0, out1            core results
//     out0_ready/out1_ready core result flags, monitored for errors only
//     busy                  inference in progress (FIRE, WAIT or HOLD)
//     rdy_err               sticky result-flag error
//     done_cnt              completed result handshakes, wraps
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for four staged samples
//   FIRE  | vector on x0..x3, in_ready high for this single cycle
//   WAIT  | latency down-counter running, result flags monitored
//   HOLD  | result pair offered on m until accepted
module dnn_host_ctrl #(
    parameter int I_W     = 7,
    parameter int O_W     = 20,
    parameter int LATENCY = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dnn_host_ctrl_if.slave        s,
    dnn_host_ctrl_if.master       m,
    output logic signed [I_W-1:0] x0,
    output logic signed [I_W-1:0] x1,
    output logic signed [I_W-1:0] x2,
    output logic signed [I_W-1:0] x3,
    output logic                  in_ready,
    input  logic signed [O_W-1:0] out0,
    input  logic signed [O_W-1:0] out1,
    input  logic                  out0_ready,
    input  logic                  out1_ready,
    output logic                  busy,
    output logic                  rdy_err,
    output logic [15:0]           done_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FIRE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // WAIT reaches terminal count exactly LATENCY cycles after FIRE.
    localparam logic [3:0] WCNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]           state;
    logic [2:0]           scnt;
    logic signed [I_W-1:0] stg [4];
    logic signed [I_W-1:0] s_data;
    logic                 s_ready;
    logic                 accept;
    logic                 launch;
    logic [3:0]           wcnt;
    logic                 pair_seen;
    logic                 m_valid_q;
    logic [2*O_W-1:0]     m_data_q;
    logic                 both_rdy;
    logic                 split_rdy;
    logic                 capture;
    logic                 handshake;

    assign s_data    = s.data;
    assign s_ready   = (scnt < 3'd4);
    assign s.ready   = s_ready;
    assign accept    = s.valid & s_ready;

    // scnt==4 blocks accepts, so a launch never coincides with a beat.
    assign launch    = (state == ST_IDLE) && (scnt == 3'd4);

    assign both_rdy  = out0_ready & out1_ready;
    assign split_rdy = out0_ready ^ out1_ready;
    assign capture   = (state == ST_WAIT) && (wcnt == 4'd0);
    assign handshake = (state == ST_HOLD) && m_valid_q && m.ready;

    assign m.valid   = m_valid_q;
    assign m.data    = m_data_q;
    assign busy      = (state != ST_IDLE);

    // Staging keeps filling in every state so the next vector is ready
    // while the current one is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                stg[i] <= '0;
            end
        end else if (launch) begin
            scnt <= 3'd0;
        end else if (accept) begin
            stg[scnt[1:0]] <= s_data;
            scnt           <= scnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            x3        <= '0;
            in_ready  <= 1'b0;
            wcnt      <= 4'd0;
            pair_seen <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            rdy_err   <= 1'b0;
            done_cnt  <= 16'd0;
        end else begin
            // High only during FIRE, which always follows a launch.
            in_ready <= launch;

            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        x0    <= stg[0];
                        x1    <= stg[1];
                        x2    <= stg[2];
                        x3    <= stg[3];
                        state <= ST_FIRE;
                    end
                end

                ST_FIRE: begin
                    wcnt      <= WCNT_LOAD;
                    pair_seen <= 1'b0;
                    state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    pair_seen <= pair_seen | both_rdy;
                    if (split_rdy) begin
                        rdy_err <= 1'b1;
                    end
                    if (capture) begin
                        m_data_q  <= {out0, out1};
                        m_valid_q <= 1'b1;
                        state     <= ST_HOLD;
                        // The capture cycle itself still counts as a
                        // chance for the flags to have been seen together.
                        if (!(pair_seen | both_rdy)) begin
                            rdy_err <= 1'b1;
                        end
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end

                ST_HOLD: begin
                    if (handshake) begin
                        m_valid_q <= 1'b0;
                        done_cnt  <= done_cnt + 16'd1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_host_ctrl.sv
// tb_dnn_host_ctrl
//   Two controllers (LATENCY 6 and 3) share clock and reset. A cycle-stepped
//   stimulus process drives both; a reference model built from queues of
//   accepted samples and core results predicts launches, captured values,
//   error flag and handshake count.
module tb_dnn_host_ctrl;

    localparam int I_W  = 7;
    localparam int O_W  = 20;
    localparam int LAT0 = 6;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [1:0]          s_valid;
    logic [1:0][I_W-1:0] s_data;
    logic [1:0]          m_ready;
    logic [1:0][O_W-1:0] out0;
    logic [1:0][O_W-1:0] out1;
    logic [1:0]          out0_ready;
    logic [1:0]          out1_ready;

    wire [1:0]           s_ready;
    wire [1:0]           m_valid;
    wire [1:0]           in_ready;
    wire [1:0]           busy;
    wire [1:0]           rdy_err;
    wire [1:0][I_W-1:0]  x0;
    wire [1:0][I_W-1:0]  x1;
    wire [1:0][I_W-1:0]  x2;
    wire [1:0][I_W-1:0]  x3;
    wire [1:0][O_W-1:0]  m_out0;
    wire [1:0][O_W-1:0]  m_out1;
    wire [1:0][15:0]     done_cnt;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dnn_host_ctrl_if #(.W(I_W))   sif ();
        dnn_host_ctrl_if #(.W(2*O_W)) mif ();

        assign sif.valid  = s_valid[g];
        assign sif.data   = s_data[g];
        assign s_ready[g] = sif.ready;
        assign mif.ready  = m_ready[g];
        assign m_valid[g] = mif.valid;
        assign m_out0[g]  = mif.data[2*O_W-1:O_W];
        assign m_out1[g]  = mif.data[O_W-1:0];

        dnn_host_ctrl #(
            .I_W     (I_W),
            .O_W     (O_W),
            .LATENCY ((g == 0) ? LAT0 : LAT1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .s          (sif.slave),
            .m          (mif.master),
            .x0         (x0[g]),
            .x1         (x1[g]),
            .x2         (x2[g]),
            .x3         (x3[g]),
            .in_ready   (in_ready[g]),
            .out0       (out0[g]),
            .out1       (out1[g]),
            .out0_ready (out0_ready[g]),
            .out1_ready (out1_ready[g]),
            .busy       (busy[g]),
            .rdy_err    (rdy_err[g]),
            .done_cnt   (done_cnt[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // reference model state, one slot per DUT
    logic [I_W-1:0]   stage_q [2][$];
    logic [I_W-1:0]   dir_q   [2][$];
    logic [2*O_W-1:0] res_q   [2][$];
    logic [2*O_W-1:0] fix_q   [2][$];
    logic [I_W-1:0]   cur_vec [2][4];
    logic [2*O_W-1:0] pend    [2];
    logic [15:0]      done_exp[2];
    bit               inflight[2];
    bit               exp_fire[2];
    bit               active  [2];
    bit               prev_mv [2];
    bit               err_exp [2];
    int               age     [2];
    int               fire_cyc[2];
    int               feed    [2];
    int               vprob   [2];
    int               mr_mode [2];   // 0: always ready, 1: random, 2: stalled
    int               resp_mode[2];  // 0: good flags, 1: never ready, 2: split

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string tg(input int d, input string n);
        return $sformatf("dut%0d.%s", d, n);
    endfunction

    task automatic chk_x(input int d);
        check(tg(d, "x0"), x0[d], cur_vec[d][0]);
        check(tg(d, "x1"), x1[d], cur_vec[d][1]);
        check(tg(d, "x2"), x2[d], cur_vec[d][2]);
        check(tg(d, "x3"), x3[d], cur_vec[d][3]);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            stage_q[d].delete();
            dir_q[d].delete();
            res_q[d].delete();
            fix_q[d].delete();
            done_exp[d] = 16'd0;
            inflight[d] = 1'b0;
            exp_fire[d] = 1'b0;
            active[d]   = 1'b0;
            prev_mv[d]  = 1'b0;
            err_exp[d]  = 1'b0;
            age[d]      = 0;
            feed[d]     = 0;
            pend[d]     = '0;
        end
        s_valid    = '0;
        s_data     = '0;
        m_ready    = '0;
        out0       = '0;
        out1       = '0;
        out0_ready = '0;
        out1_ready = '0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the
    // model with this cycle's transfers, then move to the next falling edge.
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = (feed[d] > 0) && ($urandom_range(99) < vprob[d]);
            s_data[d]  = (dir_q[d].size() > 0) ? dir_q[d][0] : I_W'($urandom);
            case (mr_mode[d])
                0:       m_ready[d] = 1'b1;
                1:       m_ready[d] = 1'($urandom_range(1));
                default: m_ready[d] = 1'b0;
            endcase
        end

        for (int d = 0; d < 2; d++) begin
            int lat;
            logic [2*O_W-1:0] r;
            lat = (d == 0) ? LAT0 : LAT1;

            check(tg(d, "in_ready"), in_ready[d], exp_fire[d]);
            check(tg(d, "rdy_err"), rdy_err[d], err_exp[d]);
            check(tg(d, "done_cnt"), done_cnt[d], done_exp[d]);

            if (in_ready[d]) begin
                check(tg(d, "launch_with_m_valid"), m_valid[d], 1'b0);
                for (int i = 0; i < 4; i++) begin
                    cur_vec[d][i] = (stage_q[d].size() > 0) ? stage_q[d].pop_front() : '0;
                end
                chk_x(d);
                inflight[d] = 1'b1;
                fire_cyc[d] = cyc;
                active[d]   = 1'b1;
                age[d]      = 0;
                if (fix_q[d].size() > 0) pend[d] = fix_q[d].pop_front();
                else                     pend[d] = {O_W'($urandom), O_W'($urandom)};
            end else begin
                if (inflight[d]) chk_x(d);
                if (active[d])   age[d]++;
            end

            check(tg(d, "busy"), busy[d], inflight[d]);

            if (m_valid[d] && !prev_mv[d]) begin
                check(tg(d, "capture_time"), cyc, fire_cyc[d] + lat + 1);
            end
            if (m_valid[d]) begin
                if (res_q[d].size() > 0) begin
                    r = res_q[d][0];
                    check(tg(d, "m_out0"), m_out0[d], r[2*O_W-1:O_W]);
                    check(tg(d, "m_out1"), m_out1[d], r[O_W-1:0]);
                end else begin
                    check(tg(d, "spurious_m_valid"), m_valid[d], 1'b0);
                end
            end
            prev_mv[d] = m_valid[d];

            // An idle controller with four samples staged launches next cycle.
            exp_fire[d] = !inflight[d] && (stage_q[d].size() == 4);

            check(tg(d, "s_ready"), s_ready[d], stage_q[d].size() < 4);
            if (s_valid[d] && s_ready[d]) begin
                stage_q[d].push_back(s_data[d]);
                feed[d]--;
                if (dir_q[d].size() > 0) void'(dir_q[d].pop_front());
            end
            if (m_valid[d] && m_ready[d]) begin
                if (res_q[d].size() > 0) void'(res_q[d].pop_front());
                done_exp[d] = done_exp[d] + 16'd1;
                inflight[d] = 1'b0;
            end

            // core behaviour: result valid only in the cycle LATENCY after launch
            if (active[d] && age[d] >= 1) begin
                out0_ready[d] = (resp_mode[d] != 1) && (age[d] >= ((resp_mode[d] == 2) ? 2 : 3));
                out1_ready[d] = (resp_mode[d] != 1) && (age[d] >= 3);
                if (resp_mode[d] == 2 && age[d] == 2) err_exp[d] = 1'b1;
            end else begin
                out0_ready[d] = 1'b0;
                out1_ready[d] = 1'b0;
            end
            if (active[d] && age[d] == lat) begin
                out0[d] = pend[d][2*O_W-1:O_W];
                out1[d] = pend[d][O_W-1:0];
                res_q[d].push_back(pend[d]);
                if (resp_mode[d] == 1) err_exp[d] = 1'b1;
                active[d] = 1'b0;
            end else begin
                out0[d] = ~pend[d][2*O_W-1:O_W];
                out1[d] = ~pend[d][O_W-1:0];
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic bit quiet();
        for (int d = 0; d < 2; d++) begin
            if (feed[d] != 0 || stage_q[d].size() != 0 || inflight[d] ||
                active[d] || res_q[d].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_until_quiet(input int budget);
        bit q;
        q = quiet();
        for (int i = 0; i < budget && !q; i++) begin
            step();
            q = quiet();
        end
        check("quiet_within_budget", q, 1'b1);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_mvalid(input int d, input int budget);
        for (int i = 0; i < budget && !m_valid[d]; i++) step();
        check(tg(d, "m_valid_within_budget"), m_valid[d], 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check(tg(d, "rst_in_ready"), in_ready[d], 1'b0);
            check(tg(d, "rst_m_valid"), m_valid[d], 1'b0);
            check(tg(d, "rst_busy"), busy[d], 1'b0);
        end
        clear_model();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check(tg(d, "rst_x0"), x0[d], '0);
            check(tg(d, "rst_x3"), x3[d], '0);
            check(tg(d, "rst_m_out0"), m_out0[d], '0);
            check(tg(d, "rst_m_out1"), m_out1[d], '0);
            check(tg(d, "rst_rdy_err"), rdy_err[d], 1'b0);
            check(tg(d, "rst_done_cnt"), done_cnt[d], '0);
            check(tg(d, "rst_s_ready"), s_ready[d], 1'b1);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bit reached;
        vprob     = '{100, 100};
        mr_mode   = '{0, 0};
        resp_mode = '{0, 0};
        clear_model();
        do_reset();

        // single inference on the 6-stage controller
        dir_q[0].push_back(I_W'(1));
        dir_q[0].push_back(I_W'(2));
        dir_q[0].push_back(I_W'(3));
        dir_q[0].push_back(I_W'(-4));
        fix_q[0].push_back({O_W'(123), O_W'(-7)});
        feed[0] = 4;
        run_until_quiet(200);
        check("single_done_cnt", done_cnt[0], 16'd1);
        check("single_rdy_err", rdy_err[0], 1'b0);

        // downstream backpressure while the next vector stages
        mr_mode[0] = 2;
        feed[0]    = 4;
        wait_mvalid(0, 100);
        feed[0] = 4;
        run_n(10);
        check("bp_s_ready", s_ready[0], 1'b0);
        check("bp_m_valid", m_valid[0], 1'b1);
        mr_mode[0] = 0;
        run_until_quiet(200);

        // result flags never seen, then a good inference keeps the flag
        resp_mode[0] = 1;
        feed[0]      = 4;
        run_until_quiet(200);
        check("noready_rdy_err", rdy_err[0], 1'b1);
        resp_mode[0] = 0;
        feed[0]      = 4;
        run_until_quiet(200);
        check("sticky_rdy_err", rdy_err[0], 1'b1);

        // split flags on the 3-stage controller
        resp_mode[1] = 2;
        feed[1]      = 4;
        run_until_quiet(200);
        check("split_rdy_err", rdy_err[1], 1'b1);
        resp_mode[1] = 0;

        // reset in WAIT with two samples staged
        feed[0] = 6;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            step();
            reached = inflight[0] && active[0] && age[0] >= 2 && stage_q[0].size() == 2;
        end
        check("midrst_reached_wait", reached, 1'b1);
        do_reset();
        feed[0] = 4;
        run_until_quiet(200);
        check("midrst_done_cnt", done_cnt[0], 16'd1);

        // extreme sample and result values on the 3-stage controller
        dir_q[1].push_back(I_W'(-64));
        dir_q[1].push_back(I_W'(63));
        dir_q[1].push_back(I_W'(-64));
        dir_q[1].push_back(I_W'(63));
        dir_q[1].push_back(I_W'(63));
        dir_q[1].push_back(I_W'(-64));
        dir_q[1].push_back(I_W'(63));
        dir_q[1].push_back(I_W'(-64));
        fix_q[1].push_back({O_W'(524287), O_W'(-524288)});
        fix_q[1].push_back({O_W'(-524287), O_W'(-524288)});
        feed[1] = 8;
        run_until_quiet(200);

        // handshake counter wrap
        force g_dut[0].u_dut.done_cnt = 16'hFFFE;
        #1;
        release g_dut[0].u_dut.done_cnt;
        done_exp[0] = 16'hFFFE;
        feed[0]     = 8;
        run_until_quiet(300);
        check("wrap_done_cnt", done_cnt[0], 16'h0000);

        // randomized traffic on both controllers
        for (int d = 0; d < 2; d++) begin
            vprob[d]   = $urandom_range(100, 30);
            mr_mode[d] = 1;
            feed[d]    = 4 * 12;
        end
        run_until_quiet(4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dnn_host_ctrl.md
Name: dnn_host_ctrl

Overview:
- Host-side driver for the 4-input / 2-output DNN inference datapath.
- Accepts a stream of signed input samples on a valid/ready slave port and double-buffers them into 4-element vectors.
- Presents each vector on x0..x3 with a one-cycle in_ready strobe, then captures out0/out1 a fixed LATENCY later.
- Returns the result pair on a valid/ready master port. It sits between the system bus adapter and the DNN core.

Parameters:
- I_W, 7, signed input sample width; must match the DNN core's input width.
- O_W, 20, signed result width; must equal I_W+13.
- LATENCY, 6, cycles from the in_ready-high cycle to the cycle in which out0/out1 are sampled (6 for the 6-stage core, 3 for the 3-stage core). Legal range 2..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid&s_ready.
- s_data  in  I_W  signed sample; beats 0..3 map to x0..x3.
- x0, x1, x2, x3  out  I_W each  registered vector to the DNN core.
- in_ready  out  1  registered one-cycle launch strobe to the DNN core.
- out0, out1  in  O_W each  DNN results.
- out0_ready, out1_ready  in  1 each  DNN result-ready flags (monitored only).
- m_valid  out  1  result pair valid.
- m_ready  in  1  downstream accepts the result when m_valid&m_ready.
- m_out0, m_out1  out  O_W each  captured results.
- busy  out  1  high in FIRE, WAIT or HOLD.
- rdy_err  out  1  sticky handshake error flag.
- done_cnt  out  16  count of completed result handshakes; wraps 0xFFFF->0.

Behaviour:
- Reset: async assert clears everything to 0 — x0..x3, in_ready, m_valid, m_out0/1, rdy_err, done_cnt, staging count. FSM goes to IDLE. Staging contents and any in-flight inference are discarded. in_ready deasserts immediately on rst_n low.
- Staging buffer:
  - 4 entries, count scnt 0..4; s_ready = (scnt<4), derived combinationally from the registered scnt.
  - An accepted beat writes entry scnt and increments scnt.
  - Staging fills in every FSM state, so the next vector loads while the current one is in flight.
- FSM states: IDLE, FIRE, WAIT, HOLD.
- IDLE: if scnt==4, copy entries 0..3 to x0..x3, set scnt to 0, go to FIRE. No beat is accepted that cycle because s_ready=0 at scnt==4.
- FIRE:
  - in_ready=1 for exactly this one cycle; load wait counter wcnt=LATENCY-1; go to WAIT.
  - x0..x3 must stay unchanged from FIRE until the FSM leaves HOLD.
- WAIT:
  - Decrement wcnt each cycle.
  - On the cycle wcnt==0, i.e. FIRE cycle + LATENCY, register out0/out1 into m_out0/m_out1, set m_valid=1 from the next cycle, and go to HOLD.
  - Track whether out0_ready&out1_ready was high in any cycle from FIRE+1 through the capture cycle. If never, set rdy_err at capture.
  - out0_ready!=out1_ready in any WAIT cycle also sets rdy_err.
  - rdy_err clears only on reset.
- HOLD:
  - m_valid held high; m_out0/m_out1 held stable.
  - On m_valid&m_ready: m_valid=0 next cycle, done_cnt+1, go to IDLE.
  - If scnt==4 at that moment, the next launch happens in the following IDLE cycle (one bubble cycle; no same-cycle chaining).
- Timing, back-to-back (scnt already 4, m_ready tied 1): one result per LATENCY+3 cycles.
- Arithmetic: results are passed through bit-exact, with no sign extension, saturation or rounding. Inputs are sampled as signed I_W with no modification.
- Simultaneous events: a beat accept and a launch cannot coincide (scnt==4 gates both). A beat accept in HOLD during the m_ready handshake is legal and independent.
- in_ready is never high in two consecutive cycles, and is never high while m_valid=1.

Test Plan:
- Single inference: reset, send beats 1,2,3,-4 -> x0..x3=1,2,3,-4 from the FIRE cycle; in_ready high exactly 1 cycle. Bench drives out0=20'sd123, out1=-20'sd7 only in cycle FIRE+6 and out0_ready=out1_ready=1 from FIRE+3 -> m_valid rises at FIRE+7 with m_out0=123, m_out1=-7; rdy_err=0; done_cnt=1.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid rises and stream 4 more beats -> s_ready=0 after the 4th beat; m_out stable; x0..x3 unchanged; no in_ready. Release m_ready -> second FIRE follows exactly 2 cycles after the handshake cycle.
- Ready error: keep out0_ready=out1_ready=0 through WAIT -> result is still delivered; rdy_err=1 and stays 1 across a subsequent good inference. Separately, out0_ready=1 with out1_ready=0 in one WAIT cycle -> rdy_err=1.
- Reset mid-operation: pull rst_n low during WAIT with 2 beats staged -> in_ready, m_valid and busy read 0 immediately; scnt=0 after release. A fresh 4 beats produce a normal result and done_cnt=1.
- Boundary values: beats -64, 63, -64, 63 (I_W=7) with LATENCY=3 -> x regs hold exact two's-complement values. Capture occurs at FIRE+3; m_out equals the bench-driven ±524287 / -524288 values bit-exact.
- Counter wrap: preload via 65536 completed handshakes (or force) -> done_cnt goes 0xFFFF then 0x0000 with no effect on the data path.
